lfsr_seq: RTL and testbench
===========================

LFSR_SEQ -- requirements
Module: lfsr_seq

Interface
REQ-001 Parameter WIDTH, default 19: number of register stages, valid range 8..64.
REQ-002 Parameter TAP_MASK [WIDTH-1:0], default 'h72000 (stages 13, 16, 17, 18): bit i set selects stage i into the feedback XOR.
REQ-003 Parameter CLK_BIT, default 8: index of the stage exported for external majority clocking.
REQ-004 Parameter LOAD_LEN, default 86: number of serial key/frame bits consumed per load.
REQ-005 Parameter WARMUP, default 100: number of mixing steps discarded before keystream output.
REQ-006 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-007 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port start, input, 1: single-cycle request to begin a load sequence.
REQ-009 Port stop, input, 1: abort or finish; returns the block to IDLE.
REQ-010 Port load_bit, input, 1: serial key/frame bit.
REQ-011 Port load_valid, input, 1: load_bit is valid.
REQ-012 Port load_ready, output, 1: block accepts load_bit this cycle.
REQ-013 Port ctrl_en, input, 1: external clock-control (majority) enable.
REQ-014 Port clk_tap, output, 1: X[CLK_BIT].
REQ-015 Port ks_bit, output, 1: X[WIDTH-1].
REQ-016 Port ks_valid, output, 1: keystream bit is valid.
REQ-017 Port ks_ready, input, 1: consumer accepts ks_bit.
REQ-018 Port X, output, WIDTH: register state; stage i is bit i, and stage 0 is the input end.
REQ-019 Port busy, output, 1: state is not IDLE.

Function
REQ-020 fb SHALL be the XOR reduction of (X & TAP_MASK); a shift SHALL set X <= {X[WIDTH-2:0], fb ^ in}.
REQ-021 The FSM SHALL have exactly these states: IDLE, CLEAR, LOAD, WARMUP, RUN.
REQ-022 IDLE: X holds. start with stop low SHALL go to CLEAR. If start and stop are both high, stop wins and the FSM stays in IDLE.
REQ-023 CLEAR: lasts one cycle. X SHALL be zeroed and the counter cleared, then the FSM goes to LOAD.
REQ-024 LOAD: load_ready SHALL be 1. On load_valid, the register shifts with in = load_bit regardless of ctrl_en, and the counter increments. After the LOAD_LEN-th accepted bit the FSM goes to WARMUP and the counter clears. A load_valid gap SHALL hold X.
REQ-025 WARMUP: each cycle the counter increments and the register shifts with in = 0 only if ctrl_en is high. After WARMUP cycles the FSM goes to RUN.
REQ-026 RUN: ks_valid SHALL be 1. On ks_valid && ks_ready the register shifts with in = 0 only if ctrl_en is high. With ks_ready low, X and ks_bit SHALL hold.
REQ-027 stop in any non-IDLE state SHALL return the FSM to IDLE on the next edge with X retained; it has priority over all other transitions.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 ks_valid and load_ready SHALL be 0 outside RUN and LOAD respectively.
REQ-030 The counter SHALL be $clog2(max(LOAD_LEN, WARMUP) + 1) bits wide and SHALL never wrap within a phase.
REQ-031 Latency: ks_valid SHALL rise exactly 1 + LOAD_LEN + WARMUP cycles after start when load_valid is held high throughout LOAD.

Reset
REQ-032 While reset_n is low: state = IDLE, X = 0, counter = 0, and all outputs = 0. A reset mid-sequence SHALL abandon the sequence with no residue.

Configuration
REQ-033 With macro LFSR_SEQ_LOCKUP_DET_EN defined, output lockup (1 bit) SHALL be registered high in RUN while X == 0, cleared on CLEAR, and 0 at reset.
REQ-034 Without LFSR_SEQ_LOCKUP_DET_EN, the lockup port and its logic SHALL be absent.

Structure
REQ-035 Package lfsr_seq_pkg SHALL hold the state enum type lfsr_state_t and the A5/1 default constants (A51_R1_MASK, A51_LOAD_LEN, A51_WARMUP).
REQ-036 Sub-module lfsr_core SHALL contain the shift register, shift enable, serial input and feedback; lfsr_seq SHALL contain the FSM and counter.

Verification
REQ-037 Reset, then start with load_bit = 1 for the first bit and 0 for the next 12 -> X == 'h01000 after the 13th accepted bit.
REQ-038 Full load of 86 zeros plus warmup -> ks_valid rises at start + 187 cycles, X == 0, and lockup == 1 when LFSR_SEQ_LOCKUP_DET_EN is defined.
REQ-039 ctrl_en = 0 for all of WARMUP -> X unchanged across all 100 cycles and ks_valid rises at the end.
REQ-040 In RUN, ks_ready = 0 for 5 cycles -> X and ks_bit stable; then ks_ready = 1 with ctrl_en = 1 -> one shift per cycle, with ks_bit matching the software model.
REQ-041 stop in LOAD after 40 bits, then start -> CLEAR zeros X, and the full 86-bit load repeats.
REQ-042 reset_n asserted in WARMUP -> busy = 0, X = 0 and ks_valid = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/lfsr_seq_pkg.sv
// lfsr_seq_pkg: sequencer state type and A5/1 register-1 default constants
package lfsr_seq_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WARMUP, RUN} lfsr_state_t;
   localparam logic [18:0] A51_R1_MASK = 19'h72000;
   localparam int A51_LOAD_LEN = 86;
   localparam int A51_WARMUP = 100;
endpackage

// File: rtl/lfsr_seq_core.sv
// lfsr_core: Fibonacci shift register with serial bit injection and synchronous clear
module lfsr_core #(
   parameter int WIDTH = 19,
   parameter logic [WIDTH-1:0] TAP_MASK = lfsr_seq_pkg::A51_R1_MASK
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             shift,
   input  logic             in_bit,
   output logic [WIDTH-1:0] x
);
   logic fb;
   assign fb = ^(x & TAP_MASK);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) x <= '0;
      else if (clr) x <= '0;
      else if (shift) x <= {x[WIDTH-2:0], fb ^ in_bit};
endmodule

// File: rtl/lfsr_seq.sv
// lfsr_seq: clear/load/warmup/run sequencer around one LFSR register.
// Defining LFSR_SEQ_LOCKUP_DET_EN adds a registered all-zero lockup flag output.
module lfsr_seq #(
   parameter int WIDTH = 19,
   parameter logic [WIDTH-1:0] TAP_MASK = lfsr_seq_pkg::A51_R1_MASK,
   parameter int CLK_BIT = 8,
   parameter int LOAD_LEN = lfsr_seq_pkg::A51_LOAD_LEN,
   parameter int WARMUP = lfsr_seq_pkg::A51_WARMUP
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             load_bit,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             ctrl_en,
   output logic             clk_tap,
   output logic             ks_bit,
   output logic             ks_valid,
   input  logic             ks_ready,
   output logic [WIDTH-1:0] X,
   output logic             busy
`ifdef LFSR_SEQ_LOCKUP_DET_EN
   ,
   output logic             lockup
`endif
);
   import lfsr_seq_pkg::*;
   localparam int CNT_MAX = (LOAD_LEN > WARMUP) ? LOAD_LEN : WARMUP;
   localparam int CW = $clog2(CNT_MAX + 1);
   lfsr_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic clr, shift, in_bit;
   lfsr_core #(.WIDTH(WIDTH), .TAP_MASK(TAP_MASK)) u_core (
      .clk(clk), .reset_n(reset_n), .clr(clr), .shift(shift), .in_bit(in_bit), .x(X)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end
   // stop overrides everything and freezes the register where it is
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      clr = 1'b0;
      shift = 1'b0;
      in_bit = 1'b0;
      if (stop) state_n = IDLE;
      else
         case (state)
            IDLE: state_n = start ? CLEAR : IDLE;
            CLEAR: begin
               clr = 1'b1;
               cnt_n = '0;
               state_n = LOAD;
            end
            LOAD:
               if (load_valid) begin
                  shift = 1'b1;
                  in_bit = load_bit;
                  cnt_n = (cnt == CW'(LOAD_LEN - 1)) ? '0 : cnt + 1'b1;
                  state_n = (cnt == CW'(LOAD_LEN - 1)) ? lfsr_seq_pkg::WARMUP : LOAD;
               end
            lfsr_seq_pkg::WARMUP: begin
               shift = ctrl_en;
               cnt_n = (cnt == CW'(WARMUP - 1)) ? '0 : cnt + 1'b1;
               state_n = (cnt == CW'(WARMUP - 1)) ? RUN : lfsr_seq_pkg::WARMUP;
            end
            RUN: shift = ks_ready & ctrl_en;
            default: state_n = IDLE;
         endcase
   end
   assign busy = state != IDLE;
   assign load_ready = state == LOAD;
   assign ks_valid = state == RUN;
   assign clk_tap = X[CLK_BIT];
   assign ks_bit = X[WIDTH-1];
`ifdef LFSR_SEQ_LOCKUP_DET_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) lockup <= 1'b0;
      else lockup <= (state == RUN) && (X == '0);
`endif
endmodule

// File: tb/tb_lfsr_seq.sv
// tb_lfsr_seq: randomized phase-by-phase check of lfsr_seq against a parity-sum register model
module tb_lfsr_seq;
   localparam int W = 19;
   localparam logic [W-1:0] TAPS = 19'h72000;
   localparam int CLKB = 8;
   localparam int LL = 86;
   localparam int WU = 100;
   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0;
   logic load_bit = 1'b0, load_valid = 1'b0, ctrl_en = 1'b0, ks_ready = 1'b0;
   logic load_ready, clk_tap, ks_bit, ks_valid, busy;
   logic [W-1:0] X;
`ifdef LFSR_SEQ_LOCKUP_DET_EN
   logic lockup;
`endif
   logic [W-1:0] mx;
   int n_vec = 0, n_err = 0;
   lfsr_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .load_bit(load_bit), .load_valid(load_valid), .load_ready(load_ready),
      .ctrl_en(ctrl_en), .clk_tap(clk_tap), .ks_bit(ks_bit), .ks_valid(ks_valid),
      .ks_ready(ks_ready), .X(X), .busy(busy)
`ifdef LFSR_SEQ_LOCKUP_DET_EN
      , .lockup(lockup)
`endif
   );
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   // new stage 0 = parity of the number of ones among tapped stages plus the injected bit
   function automatic logic [W-1:0] mstep(input logic [W-1:0] x, input logic b);
      int ones = int'(b);
      for (int i = 0; i < W; i++) if (TAPS[i]) ones += int'(x[i]);
      return {x[W-2:0], ones % 2 == 1};
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      reset_n = 1'b0;
      {start, stop, load_bit, load_valid, ctrl_en, ks_ready} = '0;
      repeat (2) tick;
      check("rst_busy", busy, 0);
      check("rst_x", X, 0);
      check("rst_ksv", ks_valid, 0);
      check("rst_ready", load_ready, 0);
      reset_n = 1'b1;
      mx = '0;
   endtask
   task automatic begin_seq;
      start = 1'b1;
      stop = 1'b0;
      tick;
      start = 1'b0;
      check("clear_busy", busy, 1);
      check("clear_ready", load_ready, 0);
      tick;
      check("clear_x", X, 0);
      check("load_ready", load_ready, 1);
      mx = '0;
   endtask
   // mode 0: zeros, 1: random bits, 2: a single one then zeros
   task automatic load(input int n, input int mode, input bit gaps);
      int acc = 0, guard = 0;
      while (acc < n && guard < 1000) begin
         logic v, b;
         v = !(gaps && $urandom_range(0, 3) == 0);
         b = (mode == 0) ? 1'b0 : (mode == 1) ? 1'($urandom) : (acc == 0);
         load_valid = v;
         load_bit = b;
         start = ($urandom_range(0, 7) == 0);
         ctrl_en = 1'($urandom);
         tick;
         if (v) begin
            mx = mstep(mx, b);
            acc++;
         end
         check("load_x", X, mx);
         guard++;
      end
      load_valid = 1'b0;
      start = 1'b0;
      check("load_done", acc, n);
      check("load_ready_end", load_ready, acc < LL);
   endtask
   // mode 0: ctrl_en low, 1: random, 2: high
   task automatic warm(input int mode, input int n);
      for (int i = 0; i < n; i++) begin
         logic c;
         c = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
         ctrl_en = c;
         ks_ready = 1'($urandom);
         load_valid = 1'($urandom);
         load_bit = 1'($urandom);
         tick;
         if (c) mx = mstep(mx, 1'b0);
         check("warm_x", X, mx);
         check("warm_ksv", ks_valid, i == WU - 1);
      end
      load_valid = 1'b0;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         logic r, c;
         r = 1'($urandom);
         c = 1'($urandom);
         ks_ready = r;
         ctrl_en = c;
         tick;
         if (r && c) mx = mstep(mx, 1'b0);
         check("run_x", X, mx);
         check("run_ks", ks_bit, mx[W-1]);
         check("run_tap", clk_tap, mx[CLKB]);
         check("run_ksv", ks_valid, 1);
      end
   endtask
   task automatic do_stop;
      stop = 1'b1;
      tick;
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_x", X, mx);
      check("stop_ksv", ks_valid, 0);
   endtask
   initial begin
      int lat;
      do_reset;
      start = 1'b1;
      stop = 1'b1;
      tick;
      {start, stop} = '0;
      check("start_stop_idle", busy, 0);
      begin_seq;
      load(13, 2, 1'b0);
      check("x_after_13", X, 19'h01000);
      do_stop;
      start = 1'b1;
      tick;
      start = 1'b0;
      load_valid = 1'b1;
      load_bit = 1'b0;
      ctrl_en = 1'b1;
      ks_ready = 1'b0;
      lat = 0;
      while (!ks_valid && lat < 400) begin
         tick;
         lat++;
      end
      load_valid = 1'b0;
      mx = '0;
      check("latency", lat, 1 + LL + WU);
      check("zero_x", X, 0);
`ifdef LFSR_SEQ_LOCKUP_DET_EN
      tick;
      check("lockup", lockup, 1);
`endif
      do_stop;
      begin_seq;
      load(LL, 1, 1'b1);
      warm(0, WU);
      ks_ready = 1'b0;
      repeat (5) begin
         ctrl_en = 1'($urandom);
         tick;
         check("hold_x", X, mx);
         check("hold_ks", ks_bit, mx[W-1]);
      end
      ks_ready = 1'b1;
      ctrl_en = 1'b1;
      repeat (10) begin
         tick;
         mx = mstep(mx, 1'b0);
         check("shift_x", X, mx);
         check("shift_ks", ks_bit, mx[W-1]);
      end
      run(40);
      do_stop;
      begin_seq;
      load(40, 1, 1'b1);
      do_stop;
      begin_seq;
      load(LL, 1, 1'b1);
      warm(1, WU);
      run(60);
      do_stop;
      begin_seq;
      load(LL, 1, 1'b0);
      warm(2, 50);
      #3 reset_n = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_x", X, 0);
      check("async_ksv", ks_valid, 0);
      check("async_ready", load_ready, 0);
      tick;
      reset_n = 1'b1;
      mx = '0;
      tick;
      check("post_rst_idle", busy, 0);
      begin_seq;
      load(LL, 1, 1'b1);
      warm(1, WU);
      run(30);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
